demux14_frame: RTL and testbench
================================

DEMUX14_FRAME -- requirements
Module: demux14_frame

Interface
REQ-001 Parameter TIMEOUT, default 16: number of consecutive idle cycles (Y_valid low) allowed inside a frame before it is aborted.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Y  input  1  time-multiplexed serial data bit, slot order D1, D2, D3, D4.
REQ-006 Y_valid  input  1  Y carries a valid slot bit this cycle.
REQ-007 SYNC  input  1  marks the current valid beat as slot D1 (frame start); ignored when Y_valid is low.
REQ-008 D1, D2, D3, D4  output  1 each  registered demultiplexed slot values of the last complete frame.
REQ-009 S  output  2  index of the slot the next valid beat will fill (0 = D1 … 3 = D4).
REQ-010 FRAME_VALID  output  1  one-cycle pulse: D1..D4 just updated with a complete frame.
REQ-011 ERR  output  1  one-cycle pulse: a partial frame was discarded.
REQ-012 FRAME_CNT  output  8  count of completed frames, wraps 255 -> 0.

Function
REQ-013 The FSM SHALL have two states: IDLE (awaiting SYNC) and COLLECT (slots 1..3 pending).
REQ-014 IDLE: a valid beat without SYNC SHALL be dropped; S stays 0; no ERR.
REQ-015 IDLE, Y_valid=1 and SYNC=1: Y SHALL be captured into shadow slot 0; S <= 1; next state COLLECT.
REQ-016 COLLECT, Y_valid=1, SYNC=0: Y SHALL be captured into shadow slot S; S <= S+1.
REQ-017 When slot 3 is captured, D1..D4 SHALL update together on that same edge (D4 = that beat's Y); FRAME_VALID = 1 for the following cycle only; FRAME_CNT increments; S <= 0; next state IDLE.
REQ-018 D1..D4 SHALL never show a mix of old and new frame bits; they change only on frame completion.
REQ-019 Latency: FRAME_VALID and new D1..D4 are visible in the cycle after the edge that samples the 4th valid beat.
REQ-020 COLLECT, Y_valid=1, SYNC=1: the partial frame SHALL be discarded, ERR pulses 1 cycle, and the beat is taken as slot 0 of a new frame (S <= 1, stay COLLECT).
REQ-021 COLLECT, Y_valid=0: shadow and S hold; the idle counter increments; any valid beat clears it.
REQ-022 The idle counter reaching TIMEOUT SHALL abort the frame: ERR pulses 1 cycle, S <= 0, next state IDLE; D1..D4 and FRAME_CNT unchanged.
REQ-023 A back-to-back frame SHALL be accepted: SYNC on the beat immediately after slot 3 starts a new frame with no lost cycle.
REQ-024 FRAME_VALID and ERR SHALL never be high in the same cycle.

Reset
REQ-025 With rst high at a clock edge, the next cycle SHALL show: state IDLE; S=0; D1..D4=0; shadow=0; FRAME_VALID=0; ERR=0; FRAME_CNT=0; idle counter=0.
REQ-026 Reset SHALL override all inputs, including mid-frame; the partial frame is discarded with no ERR pulse.

Verification
REQ-027 Frame: SYNC+valid with Y=0,1,0,1 on 4 consecutive cycles -> D1..D4=0,1,0,1 and FRAME_VALID=1 the next cycle; FRAME_CNT=1; S sequence 0,1,2,3,0.
REQ-028 Gapped frame: beats 1,1,0,0 with 5 idle cycles between beats 2 and 3 -> D1..D4=1,1,0,0; no ERR; FRAME_VALID only after the 4th beat.
REQ-029 Resync: frame 1,1,… then SYNC on the 3rd beat followed by 0,0,1,1 -> ERR pulse on that beat; final D1..D4=0,0,1,1 (the resyncing beat is D1=0); FRAME_CNT +1 only.
REQ-030 Timeout: 2 beats then 16 idle cycles -> ERR pulse; S=0; D1..D4 and FRAME_CNT unchanged; a following valid beat without SYNC is ignored.
REQ-031 Reset mid-frame: rst after 3 beats -> all outputs 0 next cycle; no FRAME_VALID, no ERR.
REQ-032 Wrap and back-to-back: 256 consecutive back-to-back frames -> FRAME_CNT returns to 0; 256 FRAME_VALID pulses; no idle cycles between frames.

Source files
------------

// File: rtl/demux14_frame.sv
// Serial-to-parallel demultiplexer for a 4-slot frame (D1..D4) with SYNC framing,
// resync detection and an idle timeout that discards stalled partial frames.
module demux14_frame #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Y,
   input  logic       Y_valid,
   input  logic       SYNC,
   output logic       D1,
   output logic       D2,
   output logic       D3,
   output logic       D4,
   output logic [1:0] S,
   output logic       FRAME_VALID,
   output logic       ERR,
   output logic [7:0] FRAME_CNT
);

   localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      s_q, s_d;
   logic [2:0]      shadow_q, shadow_d;
   logic [3:0]      frame_q, frame_d;
   logic            fv_q, fv_d;
   logic            err_q, err_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [IW-1:0]   idle_q, idle_d;

   // NOTE: every output of this block gets a default first, so no path can leave
   // a variable unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      fv_d     = 1'b0;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      idle_d   = idle_q;

      unique case (state_q)
         IDLE: begin
            idle_d = '0;
            if (Y_valid && SYNC) begin
               shadow_d[0] = Y;
               s_d         = 2'd1;
               state_d     = COLLECT;
            end
         end
         COLLECT: begin
            if (Y_valid) begin
               idle_d = '0;
               if (SYNC) begin
                  // Resync: the partial frame is dropped and this beat becomes D1.
                  err_d       = 1'b1;
                  shadow_d[0] = Y;
                  s_d         = 2'd1;
               end else if (s_q == 2'd3) begin
                  frame_d = {shadow_q[0], shadow_q[1], shadow_q[2], Y};
                  fv_d    = 1'b1;
                  cnt_d   = cnt_q + 8'd1;
                  s_d     = 2'd0;
                  state_d = IDLE;
               end else begin
                  if (s_q == 2'd1) shadow_d[1] = Y;
                  else             shadow_d[2] = Y;
                  s_d = 2'(s_q + 2'd1);
               end
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               s_d     = 2'd0;
               idle_d  = '0;
               state_d = IDLE;
            end else begin
               idle_d = IW'(idle_q + 1'b1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments, and the reset here is
   // synchronous: it only takes effect on a rising clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         s_q      <= 2'd0;
         shadow_q <= 3'd0;
         frame_q  <= 4'd0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= 8'd0;
         idle_q   <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         idle_q   <= idle_d;
      end
   end

   assign D1          = frame_q[3];
   assign D2          = frame_q[2];
   assign D3          = frame_q[1];
   assign D4          = frame_q[0];
   assign S           = s_q;
   assign FRAME_VALID = fv_q;
   assign ERR         = err_q;
   assign FRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_demux14_frame.sv
// Scoreboard bench for demux14_frame: expected frames are queued as beats are
// driven and compared whenever FRAME_VALID pulses.
module tb_demux14_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       Y = 1'b0, Y_valid = 1'b0, SYNC = 1'b0;
   logic       D1, D2, D3, D4;
   logic [1:0] S;
   logic       FRAME_VALID, ERR;
   logic [7:0] FRAME_CNT;

   demux14_frame #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .Y(Y), .Y_valid(Y_valid), .SYNC(SYNC),
      .D1(D1), .D2(D2), .D3(D3), .D4(D4), .S(S),
      .FRAME_VALID(FRAME_VALID), .ERR(ERR), .FRAME_CNT(FRAME_CNT)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] data;
      logic [7:0] cnt;
   } frame_t;

   frame_t exp_q[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   int     err_seen = 0;
   int     err_exp = 0;
   int     fv_seen = 0;
   bit     mon_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] dout();
      return {D1, D2, D3, D4};
   endfunction

   // Outputs are sampled mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ERR === 1'b1) err_seen++;
         if (FRAME_VALID === 1'b1 || ERR === 1'b1)
            check("fv_err_exclusive", 32'(FRAME_VALID & ERR), 32'd0);
         if (FRAME_VALID === 1'b1) begin
            fv_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
               frame_t e;
               e = exp_q.pop_front();
               check("frame_data", 32'(dout()), 32'(e.data));
               check("frame_cnt", 32'(FRAME_CNT), 32'(e.cnt));
            end
         end
      end
   end

   task automatic beat(input logic y, input logic sync);
      Y = y; SYNC = sync; Y_valid = 1'b1;
      @(posedge clk); #1;
      Y_valid = 1'b0; SYNC = 1'b0;
   endtask

   task automatic idle(input int n);
      Y_valid = 1'b0; SYNC = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] v;
      int         fv_base;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      check("rst_d", 32'(dout()), 32'd0);
      check("rst_s", 32'(S), 32'd0);
      check("rst_cnt", 32'(FRAME_CNT), 32'd0);
      check("rst_fv_err", 32'({FRAME_VALID, ERR}), 32'd0);

      // Basic frame 0,1,0,1 with S sequence 0,1,2,3,0
      check("f1_s0", 32'(S), 32'd0);
      beat(1'b0, 1'b1); check("f1_s1", 32'(S), 32'd1);
      beat(1'b1, 1'b0); check("f1_s2", 32'(S), 32'd2);
      beat(1'b0, 1'b0); check("f1_s3", 32'(S), 32'd3);
      exp_q.push_back('{data: 4'b0101, cnt: 8'd1});
      beat(1'b1, 1'b0); check("f1_s_end", 32'(S), 32'd0);
      check("f1_fv", 32'(FRAME_VALID), 32'd1);
      idle(2);

      // Frame with a 5-cycle gap between beats 2 and 3
      beat(1'b1, 1'b1);
      beat(1'b1, 1'b0);
      idle(5);
      check("gap_s_hold", 32'(S), 32'd2);
      beat(1'b0, 1'b0);
      exp_q.push_back('{data: 4'b1100, cnt: 8'd2});
      beat(1'b0, 1'b0);
      idle(2);
      check("gap_no_err", 32'(err_seen), 32'(err_exp));

      // Resync on the 3rd beat
      beat(1'b1, 1'b1);
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b1);
      err_exp++;
      check("resync_err", 32'(ERR), 32'd1);
      check("resync_s", 32'(S), 32'd1);
      beat(1'b0, 1'b0);
      beat(1'b1, 1'b0);
      exp_q.push_back('{data: 4'b0011, cnt: 8'd3});
      beat(1'b1, 1'b0);
      idle(2);
      check("resync_err_count", 32'(err_seen), 32'(err_exp));

      // Timeout: 2 beats then 16 idle cycles
      beat(1'b1, 1'b1);
      beat(1'b0, 1'b0);
      idle(15);
      check("to_not_yet", 32'(ERR), 32'd0);
      check("to_s_hold", 32'(S), 32'd2);
      idle(1);
      err_exp++;
      check("to_err", 32'(ERR), 32'd1);
      check("to_s", 32'(S), 32'd0);
      check("to_d_keep", 32'(dout()), 32'b0011);
      check("to_cnt_keep", 32'(FRAME_CNT), 32'd3);
      beat(1'b1, 1'b0);
      check("to_drop_s", 32'(S), 32'd0);
      idle(6);
      check("to_err_count", 32'(err_seen), 32'(err_exp));

      // Reset after 3 beats
      beat(1'b1, 1'b1);
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);
      do_reset();
      check("mrst_d", 32'(dout()), 32'd0);
      check("mrst_s", 32'(S), 32'd0);
      check("mrst_cnt", 32'(FRAME_CNT), 32'd0);
      check("mrst_fv_err", 32'({FRAME_VALID, ERR}), 32'd0);
      beat(1'b1, 1'b0);
      check("mrst_idle_drop", 32'(S), 32'd0);
      idle(3);
      check("mrst_err_count", 32'(err_seen), 32'(err_exp));

      // 256 back-to-back frames: FRAME_CNT wraps to 0
      fv_base = fv_seen;
      for (int i = 0; i < 256; i++) begin
         v = 4'($urandom_range(0, 15));
         beat(v[3], 1'b1);
         beat(v[2], 1'b0);
         beat(v[1], 1'b0);
         exp_q.push_back('{data: v, cnt: 8'(i + 1)});
         beat(v[0], 1'b0);
      end
      idle(3);
      check("wrap_cnt", 32'(FRAME_CNT), 32'd0);
      check("wrap_pulses", 32'(fv_seen - fv_base), 32'd256);
      check("wrap_err_count", 32'(err_seen), 32'(err_exp));
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
